jtag_tap_controller: RTL

JTAG_TAP_CONTROLLER -- requirements
Module: jtag_tap_controller

---
 rtl/jtag_tap_controller_if.sv | 24 ++
 rtl/jtag_tap_controller.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/jtag_tap_controller_if.sv
// TAP serial, boundary-scan strobe and debug signals between a JTAG TAP controller and its environment.
// Carries no state of its own. The master side drives TMS/TDI/BSR_TDO, and the slave (TAP) side drives everything else.
interface jtag_tap_controller_if;
    logic       TMS;
    logic       TDI;
    logic       BSR_TDO;
    logic       ShiftDR;
    logic       ClockDR;
    logic       UpdateDR;
    logic       Mode;
    logic       TDO;
    logic       TDO_EN;
    logic [3:0] STATE;

    modport master (
        output TMS, TDI, BSR_TDO,
        input  ShiftDR, ClockDR, UpdateDR, Mode, TDO, TDO_EN, STATE
    );

    modport slave (
        input  TMS, TDI, BSR_TDO,
        output ShiftDR, ClockDR, UpdateDR, Mode, TDO, TDO_EN, STATE
    );
endinterface

// File: rtl/jtag_tap_controller.sv
// IEEE 1149.1 TAP controller with the EXTEST, SAMPLE/PRELOAD and BYPASS instructions; defining JTAG_IDCODE_EN adds IDCODE.
// Latency: the FSM advances once per TCK, BYPASS adds one TCK of TDI-to-TDO delay, and boundary TDO passes through combinationally.
// Backpressure: none. The TAP follows TMS every cycle, and Pause-DR/IR is the only way to hold a scan.
module jtag_tap_controller #(
    parameter int          IR_WIDTH     = 4,
    parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001
) (
    input  logic                 TCK,
    input  logic                 TRST,
    jtag_tap_controller_if.slave jtag
);

    if (IR_WIDTH < 2 || IDCODE_VALUE[0] != 1'b1) begin : g_param_check
        $error("jtag_tap_controller: IR_WIDTH must be >= 2 and IDCODE_VALUE[0] must be 1");
    end

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET = 4'hF,
        RUN_TEST_IDLE    = 4'hC,
        SELECT_DR        = 4'h7,
        CAPTURE_DR       = 4'h6,
        SHIFT_DR         = 4'h2,
        EXIT1_DR         = 4'h1,
        PAUSE_DR         = 4'h3,
        EXIT2_DR         = 4'h0,
        UPDATE_DR        = 4'h5,
        SELECT_IR        = 4'h4,
        CAPTURE_IR       = 4'hE,
        SHIFT_IR         = 4'hA,
        EXIT1_IR         = 4'h9,
        PAUSE_IR         = 4'hB,
        EXIT2_IR         = 4'h8,
        UPDATE_IR        = 4'hD
    } tap_state_t;

    localparam logic [IR_WIDTH-1:0] IR_EXTEST  = '0;
    localparam logic [IR_WIDTH-1:0] IR_SAMPLE  = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] IR_BYPASS  = '1;
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);
`ifdef JTAG_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(2);
    localparam logic [IR_WIDTH-1:0] IR_RESET   = IR_IDCODE;
`else
    localparam logic [IR_WIDTH-1:0] IR_RESET   = IR_BYPASS;
`endif

    tap_state_t          state;
    tap_state_t          state_nxt;
    logic [IR_WIDTH-1:0] ir;
    logic [IR_WIDTH-1:0] ir_sr;
    logic                bypass_q;
    logic                go_reset;
    logic                bnd_sel;
`ifdef JTAG_IDCODE_EN
    logic                id_sel;
    logic [31:0]         idcode_sr;
`endif

    always_ff @(posedge TCK) begin
        if (TRST) state <= TEST_LOGIC_RESET;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            TEST_LOGIC_RESET: state_nxt = jtag.TMS ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    state_nxt = jtag.TMS ? SELECT_DR        : RUN_TEST_IDLE;
            SELECT_DR:        state_nxt = jtag.TMS ? SELECT_IR        : CAPTURE_DR;
            CAPTURE_DR:       state_nxt = jtag.TMS ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         state_nxt = jtag.TMS ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         state_nxt = jtag.TMS ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         state_nxt = jtag.TMS ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         state_nxt = jtag.TMS ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        state_nxt = jtag.TMS ? SELECT_DR        : RUN_TEST_IDLE;
            SELECT_IR:        state_nxt = jtag.TMS ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       state_nxt = jtag.TMS ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         state_nxt = jtag.TMS ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         state_nxt = jtag.TMS ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         state_nxt = jtag.TMS ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         state_nxt = jtag.TMS ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        state_nxt = jtag.TMS ? SELECT_DR        : RUN_TEST_IDLE;
        endcase
    end

    // Clearing on entry into Test-Logic-Reset, rather than one cycle later, makes a TMS-driven
    // reset look identical to TRST on the very first Test-Logic-Reset cycle.
    assign go_reset = TRST || (state_nxt == TEST_LOGIC_RESET);
    assign bnd_sel  = (ir == IR_EXTEST) || (ir == IR_SAMPLE);

    always_ff @(posedge TCK) begin
        if (go_reset) begin
            ir    <= IR_RESET;
            ir_sr <= '0;
        end else begin
            if (state == UPDATE_IR) ir <= ir_sr;
            if (state == CAPTURE_IR)    ir_sr <= IR_CAPTURE;
            else if (state == SHIFT_IR) ir_sr <= {jtag.TDI, ir_sr[IR_WIDTH-1:1]};
        end
    end

    always_ff @(posedge TCK) begin
        if (go_reset || state == CAPTURE_DR) bypass_q <= 1'b0;
        else if (state == SHIFT_DR)          bypass_q <= jtag.TDI;
    end

`ifdef JTAG_IDCODE_EN
    assign id_sel = (ir == IR_IDCODE);

    always_ff @(posedge TCK) begin
        if (go_reset)                            idcode_sr <= '0;
        else if (id_sel && state == CAPTURE_DR)  idcode_sr <= IDCODE_VALUE;
        else if (id_sel && state == SHIFT_DR)    idcode_sr <= {jtag.TDI, idcode_sr[31:1]};
    end
`endif

    always_comb begin
        jtag.ShiftDR  = 1'b0;
        jtag.ClockDR  = 1'b0;
        jtag.UpdateDR = 1'b0;
        jtag.TDO      = 1'b0;
        jtag.STATE    = state;
        jtag.Mode     = (ir == IR_EXTEST);
        jtag.TDO_EN   = (state == SHIFT_DR) || (state == SHIFT_IR);
        if (bnd_sel) begin
            jtag.ShiftDR  = (state == SHIFT_DR);
            jtag.ClockDR  = (state == CAPTURE_DR) || (state == SHIFT_DR);
            jtag.UpdateDR = (state == UPDATE_DR);
        end
        if (state == SHIFT_IR) begin
            jtag.TDO = ir_sr[0];
        end else if (state == SHIFT_DR) begin
            if (bnd_sel)     jtag.TDO = jtag.BSR_TDO;
`ifdef JTAG_IDCODE_EN
            else if (id_sel) jtag.TDO = idcode_sr[0];
`endif
            else             jtag.TDO = bypass_q;
        end
    end

endmodule
